// File: rtl/flappy_frame_sequencer.sv
// Flappy Bird per-frame controller: game state plus a WAIT/BIRD/PIPE/CHECK
// sequence that updates bird physics, pipe scroll and collision/score.
module flappy_frame_sequencer #(
  parameter int BIRD_X     = 144,
  parameter int START_Y    = 320,
  parameter int BIRD_SIZE  = 16,
  parameter int GROUND_Y   = 440,
  parameter int GRAV       = 1,
  parameter int MAX_FALL   = 8,
  parameter int FLAP_VEL   = 6,
  parameter int PIPE_START = 640,
  parameter int PIPE_W     = 52,
  parameter int PIPE_SPEED = 2,
  parameter int PIPE_GAP   = 120
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Flap_Button,
  input  logic       i_Ack,
  input  logic [9:0] i_Gap_Y_In,
  output logic [9:0] o_XBird,
  output logic [9:0] o_YBird,
  output logic [9:0] o_Pipe_X,
  output logic [9:0] o_Gap_Y,
  output logic [7:0] o_Score,
  output logic       o_Gap_Req,
  output logic       o_Overrun,
  output logic       o_q_I,
  output logic       o_q_Play,
  output logic       o_q_Lost
);

  // state  | meaning
  // IDLE   | waiting for Start, outputs at reset values
  // PLAY   | game running, phase steps once per Frame_Tick
  // LOST   | positions and score frozen until Ack
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_LOST} state_t;
  typedef enum logic [1:0] {P_WAIT, P_BIRD, P_PIPE, P_CHECK} phase_t;

  localparam logic [9:0]         C_START_Y    = 10'(START_Y);
  localparam logic [9:0]         C_PIPE_START = 10'(PIPE_START);
  localparam logic [9:0]         C_PIPE_SPEED = 10'(PIPE_SPEED);
  localparam logic signed [6:0]  C_GRAV       = 7'(GRAV);
  localparam logic signed [6:0]  C_MAX_FALL   = 7'(MAX_FALL);
  localparam logic signed [5:0]  C_FLAP_NEG   = 6'(-FLAP_VEL);
  localparam logic [11:0]        C_BIRD_X     = 12'(BIRD_X);
  localparam logic [11:0]        C_BIRD_SIZE  = 12'(BIRD_SIZE);
  localparam logic [11:0]        C_GROUND_Y   = 12'(GROUND_Y);
  localparam logic [11:0]        C_PIPE_W     = 12'(PIPE_W);
  localparam logic [11:0]        C_PIPE_GAP   = 12'(PIPE_GAP);
  localparam logic signed [11:0] C_Y_MAX      = 12'sd1023;

  state_t            r_state, w_state_nxt;
  phase_t            r_phase, w_phase_nxt;
  logic [9:0]        r_ybird, w_ybird_nxt;
  logic signed [5:0] r_vel, w_vel_nxt;
  logic [9:0]        r_pipe_x, w_pipe_x_nxt;
  logic [9:0]        r_gap_y, w_gap_y_nxt;
  logic [7:0]        r_score, w_score_nxt;
  logic              r_passed, w_passed_nxt;
  logic              r_flap_pend, w_flap_pend_nxt;
  logic              r_flap_prev;
  logic              r_gap_req, w_gap_req_nxt;
  logic              r_overrun, w_overrun_nxt;

  logic               w_flap_rise;
  logic signed [6:0]  w_vel_inc;
  logic signed [5:0]  w_vel_bird;
  logic signed [11:0] w_y_sum;
  logic [11:0]        w_y_bot;
  logic [11:0]        w_px_right;
  logic [11:0]        w_gap_bot;
  logic               w_hit_ground;
  logic               w_hit_pipe;

  assign w_flap_rise = i_Flap_Button & ~r_flap_prev;
  assign w_vel_inc   = {r_vel[5], r_vel} + C_GRAV;
  assign w_vel_bird  = r_flap_pend ? C_FLAP_NEG :
                       (w_vel_inc > C_MAX_FALL) ? C_MAX_FALL[5:0] : w_vel_inc[5:0];
  assign w_y_sum     = $signed({2'b00, r_ybird}) + $signed({{6{w_vel_bird[5]}}, w_vel_bird});

  // Collision terms see the values written back by the BIRD and PIPE phases.
  assign w_y_bot      = {2'b00, r_ybird} + C_BIRD_SIZE;
  assign w_px_right   = {2'b00, r_pipe_x} + C_PIPE_W;
  assign w_gap_bot    = {2'b00, r_gap_y} + C_PIPE_GAP;
  assign w_hit_ground = (w_y_bot >= C_GROUND_Y);
  assign w_hit_pipe   = ({2'b00, r_pipe_x} < (C_BIRD_X + C_BIRD_SIZE)) &&
                        (w_px_right > C_BIRD_X) &&
                        ((r_ybird < r_gap_y) || (w_y_bot > w_gap_bot));

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_ybird_nxt     = r_ybird;
    w_vel_nxt       = r_vel;
    w_pipe_x_nxt    = r_pipe_x;
    w_gap_y_nxt     = r_gap_y;
    w_score_nxt     = r_score;
    w_passed_nxt    = r_passed;
    w_flap_pend_nxt = r_flap_pend;
    w_gap_req_nxt   = 1'b0;
    w_overrun_nxt   = r_overrun;

    case (r_state)
      S_IDLE: begin
        if (i_Start) begin
          w_state_nxt   = S_PLAY;
          w_gap_y_nxt   = i_Gap_Y_In;
          w_gap_req_nxt = 1'b1;
        end
      end

      S_PLAY: begin
        if (i_Frame_Tick && (r_phase != P_WAIT)) w_overrun_nxt = 1'b1;
        if (w_flap_rise) w_flap_pend_nxt = 1'b1;
        case (r_phase)
          P_WAIT: begin
            if (i_Frame_Tick) w_phase_nxt = P_BIRD;
          end
          P_BIRD: begin
            w_phase_nxt     = P_PIPE;
            w_flap_pend_nxt = w_flap_rise;
            if (w_y_sum < 12'sd0) begin
              w_ybird_nxt = 10'd0;
              w_vel_nxt   = 6'sd0;
            end else begin
              w_ybird_nxt = (w_y_sum > C_Y_MAX) ? 10'd1023 : w_y_sum[9:0];
              w_vel_nxt   = w_vel_bird;
            end
          end
          P_PIPE: begin
            w_phase_nxt = P_CHECK;
            if (r_pipe_x < C_PIPE_SPEED) begin
              w_pipe_x_nxt  = C_PIPE_START;
              w_gap_y_nxt   = i_Gap_Y_In;
              w_gap_req_nxt = 1'b1;
              w_passed_nxt  = 1'b0;
            end else begin
              w_pipe_x_nxt = r_pipe_x - C_PIPE_SPEED;
            end
          end
          default: begin
            w_phase_nxt = P_WAIT;
            if (w_hit_ground || w_hit_pipe) begin
              w_state_nxt = S_LOST;
            end else if (!r_passed && (w_px_right < C_BIRD_X)) begin
              w_score_nxt  = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
              w_passed_nxt = 1'b1;
            end
          end
        endcase
      end

      S_LOST: begin
        if (i_Ack) begin
          w_state_nxt     = S_IDLE;
          w_phase_nxt     = P_WAIT;
          w_ybird_nxt     = C_START_Y;
          w_vel_nxt       = 6'sd0;
          w_pipe_x_nxt    = C_PIPE_START;
          w_gap_y_nxt     = 10'd0;
          w_score_nxt     = 8'd0;
          w_passed_nxt    = 1'b0;
          w_flap_pend_nxt = 1'b0;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      r_state     <= S_IDLE;
      r_phase     <= P_WAIT;
      r_ybird     <= C_START_Y;
      r_vel       <= 6'sd0;
      r_pipe_x    <= C_PIPE_START;
      r_gap_y     <= 10'd0;
      r_score     <= 8'd0;
      r_passed    <= 1'b0;
      r_flap_pend <= 1'b0;
      r_flap_prev <= 1'b0;
      r_gap_req   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_ybird     <= w_ybird_nxt;
      r_vel       <= w_vel_nxt;
      r_pipe_x    <= w_pipe_x_nxt;
      r_gap_y     <= w_gap_y_nxt;
      r_score     <= w_score_nxt;
      r_passed    <= w_passed_nxt;
      r_flap_pend <= w_flap_pend_nxt;
      r_flap_prev <= i_Flap_Button;
      r_gap_req   <= w_gap_req_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign o_XBird   = 10'(BIRD_X);
  assign o_YBird   = r_ybird;
  assign o_Pipe_X  = r_pipe_x;
  assign o_Gap_Y   = r_gap_y;
  assign o_Score   = r_score;
  assign o_Gap_Req = r_gap_req;
  assign o_Overrun = r_overrun;
  assign o_q_I     = (r_state == S_IDLE);
  assign o_q_Play  = (r_state == S_PLAY);
  assign o_q_Lost  = (r_state == S_LOST);

endmodule

// File: tb/tb_flappy_frame_sequencer.sv
// Scoreboard bench for flappy_frame_sequencer: directed frames push expected
// snapshots; a negedge monitor compares them and every Gap_Req pulse.
module tb_flappy_frame_sequencer;

  localparam int IDLE = 4, PLAY = 2, LOST = 1;

  typedef struct {
    int    due;
    string name;
    int    y, px, gy, sc, fl, ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, tick, start, btn, ack;
  logic [9:0] gin;
  logic [9:0] xbird, ybird, pipe_x, gap_y;
  logic [7:0] score;
  logic       gap_req, overrun, q_i, q_play, q_lost;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   gap_q[$];

  flappy_frame_sequencer dut (
    .i_Clk(clk), .i_Reset(rst_n), .i_Frame_Tick(tick), .i_Start(start),
    .i_Flap_Button(btn), .i_Ack(ack), .i_Gap_Y_In(gin),
    .o_XBird(xbird), .o_YBird(ybird), .o_Pipe_X(pipe_x), .o_Gap_Y(gap_y),
    .o_Score(score), .o_Gap_Req(gap_req), .o_Overrun(overrun),
    .o_q_I(q_i), .o_q_Play(q_play), .o_q_Lost(q_lost)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, act, expv, cyc);
    end
  endtask

  function automatic exp_t E(input string n, input int y, input int px, input int gy,
                             input int sc, input int fl, input int ov);
    exp_t e;
    e.due = 0; e.name = n; e.y = y; e.px = px; e.gy = gy; e.sc = sc; e.fl = fl; e.ov = ov;
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      if (e.due < cyc) begin
        check({e.name, "_missed"}, cyc, e.due);
      end else begin
        check({e.name, "_ybird"}, int'(ybird), e.y);
        check({e.name, "_pipe_x"}, int'(pipe_x), e.px);
        check({e.name, "_gap_y"}, int'(gap_y), e.gy);
        check({e.name, "_score"}, int'(score), e.sc);
        check({e.name, "_state"}, int'({q_i, q_play, q_lost}), e.fl);
        check({e.name, "_overrun"}, int'(overrun), e.ov);
        check({e.name, "_xbird"}, int'(xbird), 144);
      end
    end
    if (gap_req) begin
      if (gap_q.size() == 0) check("gap_req_unexpected", 1, 0);
      else check("gap_req_gap_y", int'(gap_y), gap_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input exp_t e);
    e.due = cyc;
    exp_q.push_back(e);
  endtask

  // One frame: optional flap edge, then a tick; outputs final 4 edges after raising tick.
  task automatic frame(input bit flap, input bit chk, input exp_t e, input bit ovr_tick);
    if (flap) begin
      btn = 1'b1; step();
      btn = 1'b0; step();
    end
    tick = 1'b1;
    if (chk) begin
      e.due = cyc + 4;
      exp_q.push_back(e);
    end
    step();
    if (!ovr_tick) tick = 1'b0;
    step();
    tick = 1'b0;
    step();
    step();
  endtask

  exp_t nx;

  initial begin
    nx = E("-", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; tick = 1'b0; start = 1'b0; btn = 1'b0; ack = 1'b0; gin = 10'd0;
    repeat (3) step();
    rst_n = 1'b1;
    expect_now(E("reset", 320, 640, 0, 0, IDLE, 0));
    step();

    // Free fall to the ground
    gin = 10'd300; gap_q.push_back(300);
    start = 1'b1; step(); start = 1'b0;
    frame(0, 1, E("fall_f1", 321, 638, 300, 0, PLAY, 0), 0);
    repeat (8) frame(0, 0, nx, 0);
    frame(0, 1, E("fall_f10", 372, 620, 300, 0, PLAY, 0), 0);
    repeat (5) frame(0, 0, nx, 0);
    frame(0, 1, E("fall_f16", 420, 608, 300, 0, PLAY, 0), 0);
    frame(0, 1, E("lost_f17", 428, 606, 300, 0, LOST, 0), 0);
    frame(1, 1, E("lost_frozen", 428, 606, 300, 0, LOST, 0), 0);
    ack = 1'b1; step(); ack = 1'b0;
    expect_now(E("ack_idle", 320, 640, 0, 0, IDLE, 0));
    frame(1, 1, E("idle_hold", 320, 640, 0, 0, IDLE, 0), 0);

    // Flap and overrun
    gin = 10'd200; gap_q.push_back(200);
    start = 1'b1; step(); start = 1'b0;
    frame(1, 1, E("flap_f1", 314, 638, 200, 0, PLAY, 0), 0);
    frame(0, 1, E("flap_f2", 309, 636, 200, 0, PLAY, 0), 0);
    frame(0, 1, E("ovr_f3", 305, 634, 200, 0, PLAY, 1), 1);
    frame(0, 1, E("ovr_f4", 302, 632, 200, 0, PLAY, 1), 0);

    // Reset in the middle of a sequence
    tick = 1'b1; step(); tick = 1'b0; step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    expect_now(E("rst_mid", 320, 640, 0, 0, IDLE, 0));
    step();

    // Ceiling clamp, scoring, respawn and pipe collision
    gin = 10'd0; gap_q.push_back(0);
    start = 1'b1; step(); start = 1'b0;
    for (int n = 1; n <= 562; n++) begin
      if (n == 300) begin
        gin = 10'd200;
        gap_q.push_back(200);
      end
      case (n)
        53:  frame(1, 1, E("ceil_f53", 2, 534, 0, 0, PLAY, 0), 0);
        54:  frame(1, 1, E("ceil_f54", 0, 532, 0, 0, PLAY, 0), 0);
        274: frame(1, 1, E("score_f274", 0, 92, 0, 0, PLAY, 0), 0);
        275: frame(1, 1, E("score_f275", 0, 90, 0, 1, PLAY, 0), 0);
        276: frame(1, 1, E("score_f276", 0, 88, 0, 1, PLAY, 0), 0);
        320: frame(1, 1, E("pipe_zero", 0, 0, 0, 1, PLAY, 0), 0);
        321: frame(1, 1, E("respawn", 0, 640, 200, 1, PLAY, 0), 0);
        561: frame(1, 1, E("pipe_edge", 0, 160, 200, 1, PLAY, 0), 0);
        562: frame(1, 1, E("pipe_hit", 0, 158, 200, 1, LOST, 0), 0);
        default: frame(1, 0, nx, 0);
      endcase
    end

    repeat (3) step();
    check("exp_q_drained", exp_q.size(), 0);
    check("gap_req_drained", gap_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
